adf4360_cfg_seq: RTL and testbench

- Upstream sequencer for the ADF4360 serial programmer.
- Accepts host PLL settings (R counter, A/B counters, raw config fields) and validates them.
- Packs the settings into the three 24-bit latch words (R, control, N) and drives the programmer's trigger/ready handshake.
- Stretches the trigger across the programmer's slow divided clock, detects stalls by timeout, and holds one pending request.

---
 rtl/adf4360_cfg_seq.sv | 169 ++++++++++++++++
 tb/tb_adf4360_cfg_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adf4360_cfg_seq.sv
// ADF4360 configuration sequencer: validates host PLL settings, packs the R/control/N
// latch words and handshakes them into the serial programmer with timeout and one pending slot.
module adf4360_cfg_seq #(
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned B_MIN     = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic [13:0] r_cnt_i,
    input  logic [4:0]  a_cnt_i,
    input  logic [12:0] b_cnt_i,
    input  logic [7:0]  r_cfg_i,
    input  logic [2:0]  n_cfg_i,
    input  logic [21:0] c_cfg_i,
    input  logic        prog_ready_i,
    output logic [23:0] R_o,
    output logic [23:0] C_o,
    output logic [23:0] N_o,
    output logic        trig_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic        ovf_o
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_TRIG, S_WAIT_DONE} state_t;

    typedef struct packed {
        logic [7:0]  r_cfg;
        logic [2:0]  n_cfg;
        logic [21:0] c_cfg;
        logic [13:0] r_cnt;
        logic [4:0]  a_cnt;
        logic [12:0] b_cnt;
    } fields_t;

    state_t               state_q, state_n;
    logic [TIMEOUT_W-1:0] tmo_q;
    logic                 tmo_exp;
    fields_t              req_f, sh_q, src_f;
    logic                 sh_vld_q;
    logic                 load;
    logic                 trig_n, done_n, err_n;
    logic [1:0]           err_code_n;
    logic                 legal;
    logic [13:0]          cur_r;
    logic [12:0]          cur_b;
    logic [4:0]           cur_a;

    assign req_f   = {r_cfg_i, n_cfg_i, c_cfg_i, r_cnt_i, a_cnt_i, b_cnt_i};
    assign src_f   = sh_vld_q ? sh_q : req_f;
    assign tmo_exp = &tmo_q;
    assign busy_o  = (state_q != S_IDLE);

    // Validation reads the counters back out of the packed words, which hold them until IDLE.
    assign cur_r = R_o[15:2];
    assign cur_b = N_o[20:8];
    assign cur_a = N_o[6:2];
    assign legal = (cur_r != '0) && (32'(cur_b) >= B_MIN) && (cur_b >= {8'd0, cur_a});

    always_comb begin
        state_n    = state_q;
        load       = 1'b0;
        trig_n     = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        err_code_n = err_code_o;
        unique case (state_q)
            S_IDLE: begin
                if (sh_vld_q || req_i) begin
                    load       = 1'b1;
                    err_code_n = 2'd0;
                    state_n    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!legal) begin
                    err_n      = 1'b1;
                    err_code_n = 2'd1;
                    state_n    = S_IDLE;
                end else if (prog_ready_i) begin
                    state_n = S_TRIG;
                end else if (tmo_exp) begin
                    err_n      = 1'b1;
                    err_code_n = 2'd2;
                    state_n    = S_IDLE;
                end
            end
            S_TRIG: begin
                if (!prog_ready_i) begin
                    state_n = S_WAIT_DONE;
                end else if (tmo_exp) begin
                    err_n      = 1'b1;
                    err_code_n = 2'd2;
                    state_n    = S_IDLE;
                end else begin
                    trig_n = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (prog_ready_i) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (tmo_exp) begin
                    err_n      = 1'b1;
                    err_code_n = 2'd3;
                    state_n    = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            tmo_q      <= '0;
            trig_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= '0;
            ovf_o      <= 1'b0;
            R_o        <= '0;
            C_o        <= '0;
            N_o        <= '0;
            sh_vld_q   <= 1'b0;
            sh_q       <= '0;
        end else begin
            state_q    <= state_n;
            trig_o     <= trig_n;
            done_o     <= done_n;
            err_o      <= err_n;
            err_code_o <= err_code_n;

            if (state_n != state_q) begin
                tmo_q <= '0;
            end else if (state_q != S_IDLE) begin
                tmo_q <= tmo_q + 1'b1;
            end

            if (load) begin
                R_o <= {src_f.r_cfg, src_f.r_cnt, 2'b01};
                N_o <= {1'b0, src_f.n_cfg[2], src_f.n_cfg[1], src_f.b_cnt,
                        src_f.n_cfg[0], src_f.a_cnt, 2'b10};
                C_o <= {src_f.c_cfg, 2'b00};
            end

            // In IDLE a valid shadow is consumed; a coincident request refills the freed slot.
            if (state_q == S_IDLE) begin
                if (sh_vld_q) begin
                    sh_vld_q <= req_i;
                    if (req_i) begin
                        sh_q <= req_f;
                    end
                end
            end else if (req_i) begin
                if (sh_vld_q) begin
                    ovf_o <= 1'b1;
                end else begin
                    sh_vld_q <= 1'b1;
                    sh_q     <= req_f;
                end
            end
        end
    end

endmodule

// File: tb/tb_adf4360_cfg_seq.sv
// Directed bench for adf4360_cfg_seq: a default-timeout instance for the handshake flows
// and a TIMEOUT_W=4 instance for the timeout scenarios.
module tb_adf4360_cfg_seq;

    logic        clk = 1'b0;
    logic        rst_n, req, ready, ready4;
    logic [13:0] r_cnt;
    logic [4:0]  a_cnt;
    logic [12:0] b_cnt;
    logic [7:0]  r_cfg;
    logic [2:0]  n_cfg;
    logic [21:0] c_cfg;

    logic [23:0] R_o, C_o, N_o, R4, C4, N4;
    logic        trig_o, busy_o, done_o, err_o, ovf_o;
    logic        trig4, busy4, done4, err4, ovf4;
    logic [1:0]  code_o, code4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adf4360_cfg_seq #(.TIMEOUT_W(16), .B_MIN(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .r_cnt_i(r_cnt), .a_cnt_i(a_cnt),
        .b_cnt_i(b_cnt), .r_cfg_i(r_cfg), .n_cfg_i(n_cfg), .c_cfg_i(c_cfg),
        .prog_ready_i(ready), .R_o(R_o), .C_o(C_o), .N_o(N_o), .trig_o(trig_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(code_o), .ovf_o(ovf_o)
    );

    adf4360_cfg_seq #(.TIMEOUT_W(4), .B_MIN(3)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .r_cnt_i(r_cnt), .a_cnt_i(a_cnt),
        .b_cnt_i(b_cnt), .r_cfg_i(r_cfg), .n_cfg_i(n_cfg), .c_cfg_i(c_cfg),
        .prog_ready_i(ready4), .R_o(R4), .C_o(C4), .N_o(N4), .trig_o(trig4),
        .busy_o(busy4), .done_o(done4), .err_o(err4), .err_code_o(code4), .ovf_o(ovf4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [13:0] r, input logic [4:0] a, input logic [12:0] b,
                              input logic [7:0] rc, input logic [2:0] nc, input logic [21:0] cc);
        r_cnt = r; a_cnt = a; b_cnt = b; r_cfg = rc; n_cfg = nc; c_cfg = cc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ready = 1'b1; ready4 = 1'b1;
        set_fields(14'd0, 5'd0, 13'd0, 8'd0, 3'd0, 22'd0);
        do_reset();
        tests++;
        if ({R_o, C_o, N_o, trig_o, busy_o, done_o, err_o, code_o, ovf_o} !== '0) begin
            fails++; $display("FAIL reset_main got R=%h C=%h N=%h trig=%b busy=%b ovf=%b code=%0d exp all 0",
                              R_o, C_o, N_o, trig_o, busy_o, ovf_o, code_o);
        end
        tests++;
        if ({R4, C4, N4, trig4, busy4, done4, err4, code4, ovf4} !== '0) begin
            fails++; $display("FAIL reset_t4 got R=%h C=%h N=%h trig=%b busy=%b exp all 0",
                              R4, C4, N4, trig4, busy4);
        end
    endtask

    task automatic test_legal();
        int dcnt, ecnt;
        do_reset();
        ready = 1'b1;
        set_fields(14'd10, 5'd5, 13'd100, 8'd0, 3'd0, 22'd0);
        req = 1'b1; tick(); req = 1'b0;
        tests++; if (R_o !== 24'h000029) begin fails++; $display("FAIL legal_R got %h exp 000029", R_o); end
        tests++; if (N_o !== 24'h006416) begin fails++; $display("FAIL legal_N got %h exp 006416", N_o); end
        tests++; if (C_o !== 24'h000000) begin fails++; $display("FAIL legal_C got %h exp 000000", C_o); end
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL legal_busy_t1 got %b exp 1", busy_o); end
        tick();
        tests++; if (trig_o !== 1'b0) begin fails++; $display("FAIL legal_trig_t2 got %b exp 0", trig_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++; if (trig_o !== 1'b1) begin fails++; $display("FAIL legal_trig_t%0d got %b exp 1", i + 3, trig_o); end
            tick();
        end
        ready = 1'b0;
        tick();
        tests++; if (trig_o !== 1'b0) begin fails++; $display("FAIL legal_trig_after_ack got %b exp 0", trig_o); end
        dcnt = 0; ecnt = 0;
        repeat (199) begin
            tick();
            if (done_o) dcnt++;
            if (err_o) ecnt++;
        end
        tests++; if (N_o !== 24'h006416) begin fails++; $display("FAIL legal_N_hold got %h exp 006416", N_o); end
        ready = 1'b1;
        tick();
        tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL legal_done got %b exp 1", done_o); end
        if (done_o) dcnt++;
        repeat (3) begin
            tick();
            if (done_o) dcnt++;
            if (err_o) ecnt++;
        end
        tests++; if (dcnt != 1) begin fails++; $display("FAIL legal_done_count got %0d exp 1", dcnt); end
        tests++; if (ecnt != 0) begin fails++; $display("FAIL legal_err_count got %0d exp 0", ecnt); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL legal_busy_end got %b exp 0", busy_o); end
    endtask

    task automatic test_illegal();
        logic [13:0] rv [3] = '{14'd10, 14'd0, 14'd10};
        logic [4:0]  av [3] = '{5'd0, 5'd5, 5'd20};
        logic [12:0] bv [3] = '{13'd2, 13'd100, 13'd10};
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_fields(rv[i], av[i], bv[i], 8'd0, 3'd0, 22'd0);
            req = 1'b1; tick(); req = 1'b0;
            tests++; if (code_o !== 2'd0) begin fails++; $display("FAIL illegal%0d_code_clear got %0d exp 0", i, code_o); end
            tick();
            tests++;
            if ({err_o, code_o, busy_o, trig_o} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
                fails++; $display("FAIL illegal%0d got err=%b code=%0d busy=%b trig=%b exp err=1 code=1 busy=0 trig=0",
                                  i, err_o, code_o, busy_o, trig_o);
            end
            tick();
            tests++;
            if ({err_o, code_o, trig_o} !== {1'b0, 2'd1, 1'b0}) begin
                fails++; $display("FAIL illegal%0d_hold got err=%b code=%0d trig=%b exp err=0 code=1 trig=0",
                                  i, err_o, code_o, trig_o);
            end
        end
    endtask

    task automatic test_boundary();
        do_reset();
        ready = 1'b1;
        set_fields(14'd1, 5'd3, 13'd3, 8'd0, 3'd0, 22'd0);
        req = 1'b1; tick(); req = 1'b0;
        tick();
        tests++;
        if ({err_o, busy_o} !== 2'b01) begin
            fails++; $display("FAIL boundary_accept got err=%b busy=%b exp err=0 busy=1", err_o, busy_o);
        end
        tick();
        tests++; if (trig_o !== 1'b1) begin fails++; $display("FAIL boundary_trig got %b exp 1", trig_o); end
        ready = 1'b0; tick();
        ready = 1'b1; tick();
        tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL boundary_done got %b exp 1", done_o); end
    endtask

    task automatic test_back_to_back();
        int bc;
        do_reset();
        ready = 1'b1;
        set_fields(14'd10, 5'd5, 13'd100, 8'd0, 3'd0, 22'd0);
        req = 1'b1; tick();
        set_fields(14'd20, 5'd1, 13'd50, 8'hA5, 3'b111, 22'h3ABCDE); tick();
        set_fields(14'd30, 5'd2, 13'd60, 8'h11, 3'b000, 22'h000123); tick();
        req = 1'b0;
        tests++; if (ovf_o !== 1'b1) begin fails++; $display("FAIL b2b_ovf got %b exp 1", ovf_o); end
        tests++; if (R_o !== 24'h000029) begin fails++; $display("FAIL b2b_first_R got %h exp 000029", R_o); end
        tick();
        ready = 1'b0; tick();
        repeat (10) tick();
        ready = 1'b1; tick();
        tests++;
        if ({done_o, busy_o} !== 2'b10) begin
            fails++; $display("FAIL b2b_first_done got done=%b busy=%b exp done=1 busy=0", done_o, busy_o);
        end
        tick();
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL b2b_second_start got %b exp 1", busy_o); end
        tests++; if (R_o !== 24'hA50051) begin fails++; $display("FAIL b2b_second_R got %h exp A50051", R_o); end
        tests++; if (N_o !== 24'h603286) begin fails++; $display("FAIL b2b_second_N got %h exp 603286", N_o); end
        tests++; if (C_o !== 24'hEAF378) begin fails++; $display("FAIL b2b_second_C got %h exp EAF378", C_o); end
        tick(); tick();
        tests++; if (trig_o !== 1'b1) begin fails++; $display("FAIL b2b_second_trig got %b exp 1", trig_o); end
        ready = 1'b0; tick();
        ready = 1'b1; tick();
        tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL b2b_second_done got %b exp 1", done_o); end
        bc = 0;
        repeat (5) begin tick(); if (busy_o) bc++; end
        tests++; if (bc != 0) begin fails++; $display("FAIL b2b_third_dropped busy cycles got %0d exp 0", bc); end
        tests++; if (ovf_o !== 1'b1) begin fails++; $display("FAIL b2b_ovf_sticky got %b exp 1", ovf_o); end
    endtask

    task automatic test_ack_timeout();
        int cnt, n;
        do_reset();
        ready4 = 1'b1;
        set_fields(14'd10, 5'd5, 13'd100, 8'd0, 3'd0, 22'd0);
        req = 1'b1; tick(); req = 1'b0;
        tick();
        tests++; if (trig4 !== 1'b0) begin fails++; $display("FAIL ackto_trig_t2 got %b exp 0", trig4); end
        cnt = 0; n = 0;
        do begin
            tick(); n++;
            if (trig4) cnt++;
        end while (trig4 === 1'b1 && n < 40);
        tests++; if (cnt != 15) begin fails++; $display("FAIL ackto_trig_cycles got %0d exp 15", cnt); end
        tests++;
        if ({err4, code4, busy4, trig4} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
            fails++; $display("FAIL ackto_err got err=%b code=%0d busy=%b trig=%b exp err=1 code=2 busy=0 trig=0",
                              err4, code4, busy4, trig4);
        end
    endtask

    task automatic test_done_timeout();
        int n;
        do_reset();
        ready4 = 1'b1;
        set_fields(14'd10, 5'd5, 13'd100, 8'd0, 3'd0, 22'd0);
        req = 1'b1; tick(); req = 1'b0;
        tick(); tick();
        ready4 = 1'b0; tick();
        tests++; if (trig4 !== 1'b0) begin fails++; $display("FAIL doneto_trig_after_ack got %b exp 0", trig4); end
        n = 0;
        while (err4 !== 1'b1 && n < 40) begin tick(); n++; end
        tests++; if (n != 16) begin fails++; $display("FAIL doneto_cycles got %0d exp 16", n); end
        tests++;
        if ({code4, busy4, done4} !== {2'd3, 1'b0, 1'b0}) begin
            fails++; $display("FAIL doneto_err got code=%0d busy=%b done=%b exp code=3 busy=0 done=0",
                              code4, busy4, done4);
        end
        ready4 = 1'b1;
    endtask

    task automatic test_busy_at_entry();
        int tc;
        do_reset();
        ready = 1'b0;
        set_fields(14'd10, 5'd5, 13'd100, 8'd0, 3'd0, 22'd0);
        req = 1'b1; tick(); req = 1'b0;
        tc = 0;
        repeat (5) begin tick(); if (trig_o) tc++; end
        tests++; if (tc != 0) begin fails++; $display("FAIL entry_trig_early got %0d cycles exp 0", tc); end
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL entry_busy got %b exp 1", busy_o); end
        ready = 1'b1; tick();
        tests++; if (trig_o !== 1'b0) begin fails++; $display("FAIL entry_trig_enter got %b exp 0", trig_o); end
        tick();
        tests++; if (trig_o !== 1'b1) begin fails++; $display("FAIL entry_trig got %b exp 1", trig_o); end
        ready = 1'b0; tick();
        ready = 1'b1; tick();
        tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL entry_done got %b exp 1", done_o); end
    endtask

    task automatic test_reset_mid_trig();
        int bc;
        do_reset();
        ready = 1'b1;
        set_fields(14'd10, 5'd5, 13'd100, 8'd0, 3'd0, 22'd0);
        req = 1'b1; tick(); tick(); tick();
        req = 1'b0;
        tests++;
        if ({trig_o, ovf_o} !== 2'b11) begin
            fails++; $display("FAIL rst_mid_pre got trig=%b ovf=%b exp trig=1 ovf=1", trig_o, ovf_o);
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        tests++;
        if ({R_o, C_o, N_o, trig_o, busy_o, ovf_o, code_o} !== '0) begin
            fails++; $display("FAIL rst_mid got R=%h C=%h N=%h trig=%b busy=%b ovf=%b exp all 0",
                              R_o, C_o, N_o, trig_o, busy_o, ovf_o);
        end
        bc = 0;
        repeat (3) begin tick(); if (busy_o) bc++; end
        tests++; if (bc != 0) begin fails++; $display("FAIL rst_mid_shadow_cleared busy cycles got %0d exp 0", bc); end
        set_fields(14'd7, 5'd2, 13'd9, 8'd0, 3'd0, 22'd0);
        req = 1'b1; tick(); req = 1'b0;
        tests++; if (R_o !== 24'h00001D) begin fails++; $display("FAIL rst_mid_new_R got %h exp 00001D", R_o); end
        tick(); tick();
        tests++; if (trig_o !== 1'b1) begin fails++; $display("FAIL rst_mid_new_trig got %b exp 1", trig_o); end
        ready = 1'b0; tick();
        ready = 1'b1; tick();
        tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL rst_mid_new_done got %b exp 1", done_o); end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_illegal();
        test_boundary();
        test_back_to_back();
        test_ack_timeout();
        test_done_timeout();
        test_busy_at_entry();
        test_reset_mid_trig();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
